// File: rtl/fetch_redirect_ctrl_pkg.sv
// Shared definitions for the fetch redirect controller: redirect kinds, FSM states, defaults.
// Combinational helpers only; no latency.
// No flow control.
package fetch_redirect_ctrl_pkg;

    // Numeric order equals arbitration priority.
    typedef enum logic [2:0] {
        RK_NONE = 3'd0,
        RK_BR   = 3'd1,
        RK_IRQ  = 3'd2,
        RK_MRET = 3'd3,
        RK_EXC  = 3'd4
    } redir_kind_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int       CAUSE_W_DEF   = 5;
    localparam logic [4:0] IRQ_CAUSE_DEF = 5'd11;
    localparam int       CNT_W         = 3;

    function automatic logic is_trap(input redir_kind_t k);
        return (k == RK_EXC) || (k == RK_IRQ);
    endfunction

endpackage

// File: rtl/redirect_prio_sel.sv
// Priority encoder picking the winning redirect source with its target, cause and epc.
// Zero latency, purely combinational.
// No flow control; the caller decides whether the winner is consumed.
module redirect_prio_sel
    import fetch_redirect_ctrl_pkg::*;
#(
    parameter int                 CAUSE_W   = CAUSE_W_DEF,
    parameter logic [CAUSE_W-1:0] IRQ_CAUSE = CAUSE_W'(11)
) (
    input  logic               br_taken,
    input  logic [31:0]        br_target,
    input  logic               exc_req,
    input  logic [CAUSE_W-1:0] exc_cause,
    input  logic [31:0]        exc_pc,
    input  logic               mret_req,
    input  logic [31:0]        mepc,
    input  logic [31:0]        mtvec,
    input  logic               irq_pending,
    input  logic               irq_enable,
    input  logic               commit_valid,
    input  logic [31:0]        commit_pc,
    output redir_kind_t        req_kind,
    output logic [31:0]        req_target,
    output logic [CAUSE_W-1:0] req_cause,
    output logic [31:0]        req_epc
);

    logic [31:0] trap_vec;
    assign trap_vec = mtvec & ~32'h3;

    always_comb begin
        req_kind   = RK_NONE;
        req_target = '0;
        req_cause  = '0;
        req_epc    = '0;
        if (exc_req) begin
            req_kind   = RK_EXC;
            req_target = trap_vec;
            req_cause  = exc_cause;
            req_epc    = exc_pc;
        end else if (mret_req) begin
            req_kind   = RK_MRET;
            req_target = mepc;
        end else if (irq_pending && irq_enable && commit_valid) begin
            req_kind   = RK_IRQ;
            req_target = trap_vec;
            req_cause  = IRQ_CAUSE;
            req_epc    = commit_pc;
        end else if (br_taken) begin
            req_kind   = RK_BR;
            req_target = br_target;
        end
    end

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// PC redirect scheduler: arbitrates exc/mret/irq/branch into one IF redirect plus flushes and trap commit.
// Zero-latency redirect in IDLE; held in HOLD while IF stalls; DRAIN blanks requests afterwards.
// Backpressure via if_allow_in: redirect is held (higher priority may overwrite) until IF accepts.
module fetch_redirect_ctrl
    import fetch_redirect_ctrl_pkg::*;
#(
    parameter int                 DRAIN_CYCLES = 2,
    parameter int                 CAUSE_W      = CAUSE_W_DEF,
    parameter logic [CAUSE_W-1:0] IRQ_CAUSE    = CAUSE_W'(11)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               br_taken,
    input  logic [31:0]        br_target,
    input  logic               exc_req,
    input  logic [CAUSE_W-1:0] exc_cause,
    input  logic [31:0]        exc_pc,
    input  logic               mret_req,
    input  logic [31:0]        mepc,
    input  logic [31:0]        mtvec,
    input  logic               irq_pending,
    input  logic               irq_enable,
    input  logic               commit_valid,
    input  logic [31:0]        commit_pc,
    input  logic               if_allow_in,
    output logic               redir_valid,
    output logic [31:0]        redir_target,
    output logic               flush_id,
    output logic               flush_ex,
    output logic               trap_taken,
    output logic [CAUSE_W-1:0] trap_cause,
    output logic [31:0]        trap_epc,
    output logic               in_drain
);

    state_t             state, state_nxt;
    redir_kind_t        pend_kind, pend_kind_nxt;
    logic [31:0]        pend_tgt, pend_tgt_nxt;
    logic [CNT_W-1:0]   drain_cnt, drain_cnt_nxt;

    redir_kind_t        req_kind, eff_kind;
    logic [31:0]        req_target;
    logic [CAUSE_W-1:0] req_cause;
    logic [31:0]        req_epc;

    logic               valid_c, fid_c, fex_c, trap_c, drain_c;
    logic [31:0]        tgt_c;

    redirect_prio_sel #(.CAUSE_W(CAUSE_W), .IRQ_CAUSE(IRQ_CAUSE)) u_prio (
        .br_taken     (br_taken),
        .br_target    (br_target),
        .exc_req      (exc_req),
        .exc_cause    (exc_cause),
        .exc_pc       (exc_pc),
        .mret_req     (mret_req),
        .mepc         (mepc),
        .mtvec        (mtvec),
        .irq_pending  (irq_pending),
        .irq_enable   (irq_enable),
        .commit_valid (commit_valid),
        .commit_pc    (commit_pc),
        .req_kind     (req_kind),
        .req_target   (req_target),
        .req_cause    (req_cause),
        .req_epc      (req_epc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            pend_kind <= RK_NONE;
            pend_tgt  <= '0;
            drain_cnt <= '0;
        end else begin
            state     <= state_nxt;
            pend_kind <= pend_kind_nxt;
            pend_tgt  <= pend_tgt_nxt;
            drain_cnt <= drain_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        pend_kind_nxt = pend_kind;
        pend_tgt_nxt  = pend_tgt;
        drain_cnt_nxt = drain_cnt;
        eff_kind      = RK_NONE;
        valid_c       = 1'b0;
        tgt_c         = '0;
        fid_c         = 1'b0;
        fex_c         = 1'b0;
        trap_c        = 1'b0;
        drain_c       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_kind != RK_NONE) begin
                    eff_kind = req_kind;
                    valid_c  = 1'b1;
                    tgt_c    = req_target;
                    trap_c   = is_trap(req_kind);
                    if (if_allow_in) begin
                        if (req_kind != RK_BR) begin
                            state_nxt     = ST_DRAIN;
                            drain_cnt_nxt = CNT_W'(DRAIN_CYCLES);
                        end
                    end else begin
                        state_nxt     = ST_HOLD;
                        pend_kind_nxt = req_kind;
                        pend_tgt_nxt  = req_target;
                    end
                end
            end
            ST_HOLD: begin
                valid_c  = 1'b1;
                eff_kind = pend_kind;
                tgt_c    = pend_tgt;
                // Overwrite only while IF still stalls; on the accepting cycle the held redirect wins.
                if (!if_allow_in && (req_kind > pend_kind)) begin
                    eff_kind      = req_kind;
                    tgt_c         = req_target;
                    trap_c        = is_trap(req_kind) && !is_trap(pend_kind);
                    pend_kind_nxt = req_kind;
                    pend_tgt_nxt  = req_target;
                end
                if (if_allow_in) begin
                    pend_kind_nxt = RK_NONE;
                    pend_tgt_nxt  = '0;
                    if (pend_kind != RK_BR) begin
                        state_nxt     = ST_DRAIN;
                        drain_cnt_nxt = CNT_W'(DRAIN_CYCLES);
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            ST_DRAIN: begin
                drain_c       = 1'b1;
                drain_cnt_nxt = drain_cnt - 1'b1;
                if (drain_cnt <= CNT_W'(1)) begin
                    state_nxt     = ST_IDLE;
                    drain_cnt_nxt = '0;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        fid_c = valid_c;
        fex_c = valid_c && (eff_kind != RK_BR);
    end

    // Outputs are forced low while reset is asserted, independent of the live request inputs.
    assign redir_valid  = valid_c & ~rst;
    assign redir_target = rst ? '0 : tgt_c;
    assign flush_id     = fid_c & ~rst;
    assign flush_ex     = fex_c & ~rst;
    assign trap_taken   = trap_c & ~rst;
    assign trap_cause   = (trap_c && !rst) ? req_cause : '0;
    assign trap_epc     = (trap_c && !rst) ? req_epc : '0;
    assign in_drain     = drain_c & ~rst;

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Bench for fetch_redirect_ctrl: directed literal scenarios plus randomized traffic vs a behavioural model.
module tb_fetch_redirect_ctrl;

    localparam int DRAIN = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        br_taken = 0, exc_req = 0, mret_req = 0, irq_pending = 0, irq_enable = 0;
    logic        commit_valid = 0, if_allow_in = 0;
    logic [31:0] br_target = 0, exc_pc = 0, mepc = 0, mtvec = 0, commit_pc = 0;
    logic [4:0]  exc_cause = 0;
    logic        redir_valid, flush_id, flush_ex, trap_taken, in_drain;
    logic [31:0] redir_target, trap_epc;
    logic [4:0]  trap_cause;

    int n_chk = 0;
    int n_fail = 0;

    fetch_redirect_ctrl #(.DRAIN_CYCLES(DRAIN), .CAUSE_W(5), .IRQ_CAUSE(5'd11)) dut (
        .clk(clk), .rst(rst),
        .br_taken(br_taken), .br_target(br_target),
        .exc_req(exc_req), .exc_cause(exc_cause), .exc_pc(exc_pc),
        .mret_req(mret_req), .mepc(mepc), .mtvec(mtvec),
        .irq_pending(irq_pending), .irq_enable(irq_enable),
        .commit_valid(commit_valid), .commit_pc(commit_pc),
        .if_allow_in(if_allow_in),
        .redir_valid(redir_valid), .redir_target(redir_target),
        .flush_id(flush_id), .flush_ex(flush_ex),
        .trap_taken(trap_taken), .trap_cause(trap_cause), .trap_epc(trap_epc),
        .in_drain(in_drain)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // mode: 0 idle, 1 holding a redirect, 2 blanking window
    int          m_mode = 0, m_kind = 0, m_left = 0;
    logic [31:0] m_tgt = 0;

    function automatic int winner();
        if (exc_req) return 4;
        if (mret_req) return 3;
        if (irq_pending && irq_enable && commit_valid) return 2;
        if (br_taken) return 1;
        return 0;
    endfunction

    function automatic logic [31:0] dest(input int k);
        if (k == 4 || k == 2) return {mtvec[31:2], 2'b00};
        if (k == 3) return mepc;
        return br_target;
    endfunction

    function automatic logic trapk(input int k);
        return (k == 4) || (k == 2);
    endfunction

    always @(negedge clk) begin
        int k, eff;
        logic e_v, e_trap, e_dr;
        logic [31:0] e_tgt;
        if (rst) begin
            chk("rst_outs", {redir_valid, flush_id, flush_ex, trap_taken, in_drain, redir_target},
                64'd0);
            m_mode = 0; m_kind = 0; m_left = 0; m_tgt = 0;
        end else begin
            k = winner();
            e_v = 0; e_trap = 0; e_dr = 0; e_tgt = 0; eff = 0;
            if (m_mode == 0) begin
                if (k != 0) begin
                    e_v = 1; eff = k; e_tgt = dest(k); e_trap = trapk(k);
                    if (if_allow_in) begin
                        if (k >= 2) begin m_mode = 2; m_left = DRAIN; end
                    end else begin
                        m_mode = 1; m_kind = k; m_tgt = dest(k);
                    end
                end
            end else if (m_mode == 1) begin
                e_v = 1; eff = m_kind; e_tgt = m_tgt;
                if (if_allow_in) begin
                    m_mode = (m_kind >= 2) ? 2 : 0;
                    m_left = DRAIN;
                end else if (k > m_kind) begin
                    e_trap = trapk(k) && !trapk(m_kind);
                    eff = k; e_tgt = dest(k); m_kind = k; m_tgt = e_tgt;
                end
            end else begin
                e_dr = 1;
                m_left = m_left - 1;
                if (m_left == 0) m_mode = 0;
            end
            chk("model_ctl", {redir_valid, flush_id, flush_ex, trap_taken, in_drain},
                {e_v, e_v, e_v && eff >= 2, e_trap, e_dr});
            if (e_v || e_dr) chk("model_tgt", redir_target, e_tgt);
            if (e_trap) begin
                chk("model_cause", trap_cause, (eff == 2) ? 5'd11 : exc_cause);
                chk("model_epc", trap_epc, (eff == 2) ? commit_pc : exc_pc);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic clr();
        br_taken = 0; exc_req = 0; mret_req = 0; irq_pending = 0; irq_enable = 0;
        commit_valid = 0; if_allow_in = 1;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        clr();
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        clr();
        #2;
        chk("reset_valid", {redir_valid, trap_taken, in_drain}, 3'b000);
        step(); step();
        rst = 0;
        step();

        // branch, zero latency, no drain
        br_taken = 1; br_target = 32'h100; if_allow_in = 1;
        #2;
        chk("br_ctl", {redir_valid, flush_id, flush_ex, trap_taken}, 4'b1100);
        chk("br_tgt", redir_target, 32'h100);
        step(); clr(); #2;
        chk("br_after", {redir_valid, in_drain}, 2'b00);

        // exception beats branch, drain for 2 cycles
        step();
        exc_req = 1; exc_cause = 5'd2; exc_pc = 32'h40; br_taken = 1; br_target = 32'h200;
        mtvec = 32'h81; #2;
        chk("exc_tgt", redir_target, 32'h80);
        chk("exc_ctl", {redir_valid, flush_id, flush_ex, trap_taken}, 4'b1111);
        chk("exc_cause_epc", {trap_cause, trap_epc}, {5'd2, 32'h40});
        step(); clr(); #2; chk("exc_drain1", in_drain, 1'b1);
        step(); #2;        chk("exc_drain2", in_drain, 1'b1);
        step(); #2;        chk("exc_drain_end", in_drain, 1'b0);

        // held branch overwritten by exception
        step();
        br_taken = 1; br_target = 32'h300; if_allow_in = 0; #2;
        chk("hold_c1", {redir_valid, redir_target}, {1'b1, 32'h300});
        step(); exc_req = 1; #2;
        chk("hold_c2", {redir_valid, trap_taken, redir_target}, {2'b11, 32'h80});
        step(); exc_req = 0; br_taken = 0; #2;
        chk("hold_c3", {redir_valid, flush_ex, trap_taken, redir_target}, {3'b110, 32'h80});
        step(); if_allow_in = 1; #2;
        chk("hold_done", {redir_valid, trap_taken, redir_target}, {2'b10, 32'h80});
        step(); #2; chk("hold_drain", in_drain, 1'b1);
        idle(3);

        // interrupt, then masked interrupt
        irq_pending = 1; irq_enable = 1; commit_valid = 1; commit_pc = 32'h1C; #2;
        chk("irq", {trap_taken, trap_cause, trap_epc}, {1'b1, 5'd11, 32'h1C});
        idle(3);
        irq_pending = 1; irq_enable = 0; commit_valid = 1; #2;
        chk("irq_masked", {redir_valid, trap_taken}, 2'b00);
        idle(1);

        // mret, irq held through the drain window
        mret_req = 1; mepc = 32'h1C; #2;
        chk("mret", {redir_valid, trap_taken, redir_target}, {2'b10, 32'h1C});
        step(); mret_req = 0; irq_pending = 1; irq_enable = 1; commit_valid = 1; #2;
        chk("mret_drain1", {in_drain, trap_taken}, 2'b10);
        step(); #2; chk("mret_drain2", {in_drain, trap_taken}, 2'b10);
        step(); #2; chk("irq_after_drain", {in_drain, trap_taken}, 2'b01);
        idle(3);

        // reset during HOLD
        br_taken = 1; br_target = 32'h500; if_allow_in = 0;
        step(); rst = 1; #1;
        chk("rst_hold_async", {redir_valid, flush_id, flush_ex, trap_taken, in_drain}, 5'd0);
        step(); clr(); rst = 0; #2;
        chk("rst_hold_after", {redir_valid, in_drain}, 2'b00);
        step();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            br_taken     = ($urandom_range(99) < 30);
            br_target    = $urandom & 32'hFFFF_FFFC;
            exc_req      = ($urandom_range(99) < 8);
            exc_cause    = 5'($urandom_range(31));
            exc_pc       = $urandom;
            mret_req     = ($urandom_range(99) < 8);
            mepc         = $urandom;
            mtvec        = $urandom;
            irq_pending  = ($urandom_range(99) < 25);
            irq_enable   = ($urandom_range(99) < 70);
            commit_valid = ($urandom_range(99) < 80);
            commit_pc    = $urandom;
            if_allow_in  = ($urandom_range(99) < 55);
            rst          = ($urandom_range(999) < 8);
            step();
        end
        rst = 0;
        idle(4);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
